// File: rtl/auto_brightness_ctrl.sv
// rtl/auto_brightness_ctrl.sv - frame mean-luma measurement driving binc/bdec step pulses
// Optional LUMA_WEIGHTED_EN selects (2R+5G+B)>>3 luma instead of (R+2G+B)>>2.
module auto_brightness_ctrl #(
  parameter int LOG2_PIX   = 16,
  parameter int HYST       = 8,
  parameter int STEP_SHIFT = 4,
  parameter int MAX_STEPS  = 4,
  parameter int PULSE_GAP  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       pix_valid,
  input  logic [7:0] R,
  input  logic [7:0] G,
  input  logic [7:0] B,
  input  logic       frame_en,
  input  logic [7:0] target,
  output logic       binc,
  output logic       bdec,
  output logic [7:0] avg_luma,
  output logic       avg_valid
);

  localparam int SW = 8 + LOG2_PIX;
  localparam int GW = $clog2(PULSE_GAP + 1);

  typedef enum logic [1:0] {IDLE, EVAL, PULSE, GAP} state_t;

  state_t            state, state_next;
  logic [7:0]        luma;
  logic [SW-1:0]     sum, sum_next;
  logic [LOG2_PIX:0] pix_cnt, cnt_next;
  logic              take, full;
  logic [7:0]        snap;
  logic [8:0]        diff, mag, raw;
  logic [3:0]        steps, steps_left;
  logic [GW-1:0]     gap_cnt;
  logic              dir_up;
  logic              clear;

`ifdef LUMA_WEIGHTED_EN
  logic [10:0] luma_wide;
  assign luma_wide = {2'b0, R, 1'b0} + {1'b0, G, 2'b0} + {3'b0, G} + {3'b0, B};
  assign luma      = luma_wide[10:3];
`else
  logic [9:0] luma_wide;
  assign luma_wide = {2'b0, R} + {1'b0, G, 1'b0} + {2'b0, B};
  assign luma      = luma_wide[9:2];
`endif

  assign clear = reset || !enable;

  // The pixel coinciding with frame_en still belongs to the closing frame.
  assign take     = pix_valid && !pix_cnt[LOG2_PIX];
  assign sum_next = sum + (take ? {{LOG2_PIX{1'b0}}, luma} : {SW{1'b0}});
  assign cnt_next = pix_cnt + {{LOG2_PIX{1'b0}}, take};
  assign full     = cnt_next[LOG2_PIX];

  always_ff @(posedge clk) begin
    if (clear) begin
      sum     <= '0;
      pix_cnt <= '0;
      snap    <= '0;
    end else if (frame_en) begin
      sum     <= '0;
      pix_cnt <= '0;
      snap    <= sum_next[SW-1:LOG2_PIX];
    end else begin
      sum     <= sum_next;
      pix_cnt <= cnt_next;
    end
  end

  always_comb begin
    diff  = {1'b0, snap} - {1'b0, target};
    mag   = diff[8] ? (9'd0 - diff) : diff;
    raw   = ((mag - 9'(HYST)) >> STEP_SHIFT) + 9'd1;
    steps = 4'd0;
    if (mag > 9'(HYST))
      steps = (raw > 9'(MAX_STEPS)) ? 4'(MAX_STEPS) : raw[3:0];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  state_next = IDLE;
      EVAL:  state_next = (steps == 4'd0) ? IDLE : PULSE;
      PULSE: state_next = (steps_left == 4'd1) ? IDLE : GAP;
      GAP:   state_next = (gap_cnt == GW'(1)) ? PULSE : GAP;
      default: state_next = IDLE;
    endcase
    // A new frame boundary always preempts whatever train is in flight.
    if (frame_en)
      state_next = full ? EVAL : IDLE;
    binc = (state == PULSE) && dir_up && !frame_en && !clear;
    bdec = (state == PULSE) && !dir_up && !frame_en && !clear;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state      <= IDLE;
      steps_left <= '0;
      gap_cnt    <= '0;
      dir_up     <= 1'b0;
      avg_luma   <= '0;
      avg_valid  <= 1'b0;
    end else begin
      state     <= state_next;
      avg_valid <= 1'b0;
      case (state)
        EVAL: begin
          avg_luma   <= snap;
          avg_valid  <= 1'b1;
          steps_left <= steps;
          dir_up     <= diff[8];
        end
        PULSE: begin
          steps_left <= steps_left - 4'd1;
          gap_cnt    <= GW'(PULSE_GAP);
        end
        GAP:     gap_cnt <= gap_cnt - GW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_auto_brightness_ctrl.sv
// tb/tb_auto_brightness_ctrl.sv - scoreboard bench for auto_brightness_ctrl with LOG2_PIX=4
module tb_auto_brightness_ctrl;

  localparam int NPIX = 16;

  logic       clk, reset, enable, pix_valid, frame_en;
  logic [7:0] R, G, B, target;
  logic       binc, bdec, avg_valid;
  logic [7:0] avg_luma;

  auto_brightness_ctrl #(.LOG2_PIX(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .pix_valid(pix_valid),
    .R(R), .G(G), .B(B), .frame_en(frame_en), .target(target),
    .binc(binc), .bdec(bdec), .avg_luma(avg_luma), .avg_valid(avg_valid)
  );

  typedef struct {int c; bit av; int avg; bit inc; bit dec;} ev_t;
  ev_t q[$];

  int cyc = 0;
  int vectors = 0, miscompares = 0;
  int n_av = 0, n_inc = 0, n_dec = 0, last_avg = -1;
  int mcnt = 0, msum = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int mluma(int r, int g, int b);
`ifdef LUMA_WEIGHTED_EN
    return (2 * r + 5 * g + b) / 8;
`else
    return (r + 2 * g + b) / 4;
`endif
  endfunction

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Drop future pulses at or after cycle c; published averages at c stay.
  task automatic purge(input int c, input bit keep_av_later);
    for (int i = q.size() - 1; i >= 0 && q[i].c >= c; i--) begin
      if (q[i].av && (keep_av_later || q[i].c == c)) begin
        q[i].inc = 0;
        q[i].dec = 0;
      end else q.delete(i);
    end
  endtask

  task automatic model(input int c);
    int avg, d, ad, steps;
    ev_t e;
    if (reset || !enable) begin
      mcnt = 0; msum = 0;
      purge(c, 1'b0);
      return;
    end
    if (pix_valid && mcnt < NPIX) begin
      msum += mluma(R, G, B);
      mcnt++;
    end
    if (frame_en) begin
      purge(c, 1'b1);
      if (mcnt == NPIX) begin
        avg = msum / NPIX;
        d   = avg - int'(target);
        ad  = (d < 0) ? -d : d;
        steps = (ad <= 8) ? 0 : (((ad - 8) / 16) + 1);
        if (steps > 4) steps = 4;
        e = '{c: c + 2, av: 1, avg: avg, inc: (steps > 0) && (d < 0), dec: (steps > 0) && (d > 0)};
        q.push_back(e);
        for (int k = 1; k < steps; k++)
          q.push_back('{c: c + 2 + 4 * k, av: 0, avg: 0, inc: d < 0, dec: d > 0});
      end
      mcnt = 0; msum = 0;
    end
  endtask

  task automatic tick(input bit v, input int r, input int g, input int b,
                      input bit fe, input bit rst, input bit en);
    @(posedge clk);
    #1;
    pix_valid = v; R = 8'(r); G = 8'(g); B = 8'(b);
    frame_en = fe; reset = rst; enable = en;
    model(cyc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic flat_frame(input int n, input int v);
    for (int i = 0; i < n; i++) tick(1, v, v, v, i == n - 1, 0, 1);
  endtask

  task automatic clr_counts();
    n_av = 0; n_inc = 0; n_dec = 0; last_avg = -1;
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].c < cyc) begin
      check("missed_event_cycle", cyc, q[0].c);
      void'(q.pop_front());
    end
    if (avg_valid || binc || bdec) begin
      if (avg_valid) begin n_av++; last_avg = avg_luma; end
      if (binc) n_inc++;
      if (bdec) n_dec++;
      if (q.size() == 0 || q[0].c != cyc) begin
        check("unexpected_output", {29'd0, avg_valid, binc, bdec}, 0);
      end else begin
        ev_t e;
        e = q.pop_front();
        check("avg_valid", avg_valid, e.av);
        if (e.av) check("avg_luma", avg_luma, e.avg);
        check("binc", binc, e.inc);
        check("bdec", bdec, e.dec);
      end
    end
  end

  initial begin
    reset = 1; enable = 1; pix_valid = 0; frame_en = 0;
    R = 0; G = 0; B = 0; target = 128;
    repeat (3) tick(0, 0, 0, 0, 0, 1, 1);
    #4;
    check("reset_avg_luma", avg_luma, 0);
    check("reset_avg_valid", avg_valid, 0);
    check("reset_pulses", {binc, bdec}, 0);

    // 1: dark frame, four increase pulses
    clr_counts(); target = 128;
    flat_frame(16, 8'h40); idle(20);
    check("t1_avg", last_avg, 8'h40);
    check("t1_n_inc", n_inc, 4);
    check("t1_n_dec", n_dec, 0);
    check("t1_n_av", n_av, 1);

    // 2: inside dead band
    clr_counts();
    flat_frame(16, 120); idle(10);
    check("t2_avg", last_avg, 120);
    check("t2_n_av", n_av, 1);
    check("t2_pulses", n_inc + n_dec, 0);

    // 3: bright mixed colour
    clr_counts();
    for (int i = 0; i < 16; i++) tick(1, 8'hDC, 8'hCD, 8'hEE, i == 15, 0, 1);
    idle(20);
`ifdef LUMA_WEIGHTED_EN
    check("t3_avg", last_avg, 212);
`else
    check("t3_avg", last_avg, 217);
`endif
    check("t3_n_dec", n_dec, 4);
    check("t3_n_inc", n_inc, 0);

    // 4: short frame discarded, next full frame evaluated
    clr_counts();
    flat_frame(10, 8'h40); idle(8);
    check("t4_short_av", n_av, 0);
    check("t4_short_pulses", n_inc + n_dec, 0);
    flat_frame(16, 200); idle(20);
    check("t4_avg", last_avg, 200);
    check("t4_n_dec", n_dec, 4);

    // 5: frame_en at t+7 aborts the train after two pulses
    clr_counts();
    flat_frame(16, 8'h40); idle(6);
    tick(0, 0, 0, 0, 1, 0, 1);
    idle(20);
    check("t5_n_inc", n_inc, 2);

    // 6: reset at t+5
    clr_counts();
    flat_frame(16, 8'h40); idle(4);
    tick(0, 0, 0, 0, 0, 1, 1);
    idle(20);
    check("t6_n_inc", n_inc, 1);
    check("t6_avg_luma", avg_luma, 0);

    // randomized frames: variable length, gaps, targets, colours, enable drops
    for (int f = 0; f < 40; f++) begin
      int len;
      len = $urandom_range(24, 12);
      target = 8'($urandom_range(255, 0));
      for (int i = 0; i < len; i++) begin
        if (i == len - 1)
          tick(1, $urandom_range(255, 0), $urandom_range(255, 0), $urandom_range(255, 0), 1, 0, 1);
        else
          tick($urandom_range(3, 0) != 0, $urandom_range(255, 0), $urandom_range(255, 0),
               $urandom_range(255, 0), 0, 0, $urandom_range(30, 0) != 0);
      end
      for (int i = 0, n = $urandom_range(18, 0); i < n; i++)
        tick(0, 0, 0, 0, 0, 0, $urandom_range(25, 0) != 0);
    end
    idle(30);
    check("queue_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
